// File: rtl/branch_predict_updater_pkg.sv
// Shared types and helpers for the branch-resolution update path.
// The optional BRANCH_PRED_STATS_EN macro adds resolve/mispredict counters to the top.
package branch_predict_updater_pkg;

  localparam int PHT_INDEX_W        = 10;
  localparam int BTB_INDEX_W        = 10;
  localparam int BTB_TAG_W          = 20;
  localparam int BTB_CONTENT_W      = 30;
  localparam int GLOBAL_HISTORY_W   = 6;
  localparam int UPDATE_QUEUE_DEPTH = 4;

  typedef logic [PHT_INDEX_W-1:0]      PHTIndex;
  typedef logic [BTB_INDEX_W-1:0]      BTBIndex;
  typedef logic [BTB_TAG_W-1:0]        BTBTag;
  typedef logic [BTB_CONTENT_W-1:0]    BTBContent;
  typedef logic [GLOBAL_HISTORY_W-1:0] GlobalBranchHistory;
  typedef logic [1:0]                  PHTCounter;

  localparam PHTCounter PHT_COUNTER_MAX = 2'd3;
  localparam PHTCounter PHT_COUNTER_MIN = 2'd0;

  typedef struct packed {
    PHTIndex     phtIndex;
    logic        isBranchTakenPredicted;
    logic        isNextPcPredicted;
    logic [31:0] predictedNextPC;
  } BranchPredict;

  typedef struct packed {
    BTBTag     tag;
    BTBContent content;
  } BTBEntry;

  typedef struct packed {
    logic [31:0] pc;
    logic        isConditional;
    logic        isTaken;
    logic [31:0] target;
    PHTIndex     phtIndex;
  } BranchResolve;

  function automatic BTBIndex ToBTB_Index(input logic [31:0] pc);
    return pc[BTB_INDEX_W+1:2];
  endfunction

  function automatic BTBTag ToBTB_Tag(input logic [31:0] pc);
    return pc[31:BTB_INDEX_W+2];
  endfunction

  function automatic BTBContent ToBTB_Content(input logic [31:0] target);
    return target[31:2];
  endfunction

  // 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T; saturates at both ends.
  function automatic PHTCounter NextPHTCounter(input PHTCounter cnt, input logic taken);
    if (taken)
      return (cnt == PHT_COUNTER_MAX) ? cnt : cnt + 2'd1;
    else
      return (cnt == PHT_COUNTER_MIN) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_update_queue.sv
// In-order FIFO of resolved-branch records; head is readable combinationally.
module branch_update_queue
  import branch_predict_updater_pkg::*;
#(
  parameter int DEPTH = UPDATE_QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         push,
  input  BranchResolve push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output BranchResolve head
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  BranchResolve mem_reg [DEPTH];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/branch_predict_updater.sv
// Writes resolved branch outcomes back into the PHT/BTB and keeps committed history.
// Define BRANCH_PRED_STATS_EN to add the statResolved/statMispredict counters.
module branch_predict_updater
  import branch_predict_updater_pkg::*;
#(
  parameter int QUEUE_DEPTH = UPDATE_QUEUE_DEPTH
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               resolveValid,
  output logic               resolveReady,
  input  logic [31:0]        resolvePC,
  input  logic               resolveIsConditional,
  input  logic               resolveIsTaken,
  input  logic [31:0]        resolveTarget,
  input  BranchPredict       resolvePredict,
  output PHTIndex            phtReadIndex,
  input  PHTCounter          phtReadData,
  output logic               phtWe,
  output PHTIndex            phtWriteIndex,
  output PHTCounter          phtWriteData,
  output logic               btbWe,
  output BTBIndex            btbWriteIndex,
  output BTBEntry            btbWriteEntry,
  output logic               historyRestore,
  output GlobalBranchHistory committedHistory
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]        statResolved,
  output logic [31:0]        statMispredict
`endif
);

  logic               accept;
  logic               mispredict;
  logic               q_full;
  logic               q_empty;
  BranchResolve       push_rec;
  BranchResolve       head_rec;

  logic               s1_valid_reg;
  BranchResolve       s1_rec_reg;
  logic               fwd_valid_reg;
  PHTCounter          fwd_data_reg;
  PHTCounter          base_counter;
  PHTCounter          new_counter;
  logic               pht_we;
  logic               btb_we;
  logic               fwd_next;

  GlobalBranchHistory history_reg;
  logic               restore_reg;

  assign resolveReady = rstN && !q_full;
  assign accept       = resolveValid && resolveReady;

  assign push_rec = '{pc:            resolvePC,
                      isConditional: resolveIsConditional,
                      isTaken:       resolveIsTaken,
                      target:        resolveTarget,
                      phtIndex:      resolvePredict.phtIndex};

  assign mispredict =
      (resolveIsTaken != resolvePredict.isBranchTakenPredicted) ||
      (resolveIsTaken && (!resolvePredict.isNextPcPredicted ||
                          resolvePredict.predictedNextPC != resolveTarget));

  branch_update_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rstN      (rstN),
    .push      (accept),
    .push_data (push_rec),
    .pop       (!q_empty),
    .full      (q_full),
    .empty     (q_empty),
    .head      (head_rec)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      history_reg <= '0;
      restore_reg <= 1'b0;
    end else begin
      restore_reg <= accept && mispredict;
      if (accept && resolveIsConditional)
        history_reg <= {history_reg[GLOBAL_HISTORY_W-2:0], resolveIsTaken};
    end
  end

  // The RAM returns stale data when S1 writes the index being read, so the
  // freshly computed counter is carried into the next S1 instead.
  assign base_counter = fwd_valid_reg ? fwd_data_reg : phtReadData;
  assign new_counter  = NextPHTCounter(base_counter, s1_rec_reg.isTaken);
  assign pht_we       = s1_valid_reg && s1_rec_reg.isConditional;
  assign btb_we       = s1_valid_reg && s1_rec_reg.isTaken;
  assign fwd_next     = !q_empty && pht_we && (s1_rec_reg.phtIndex == head_rec.phtIndex);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid_reg  <= 1'b0;
      s1_rec_reg    <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_data_reg  <= '0;
    end else begin
      s1_valid_reg  <= !q_empty;
      fwd_valid_reg <= fwd_next;
      fwd_data_reg  <= new_counter;
      if (!q_empty)
        s1_rec_reg <= head_rec;
    end
  end

  assign phtReadIndex     = q_empty ? '0 : head_rec.phtIndex;
  assign phtWe            = pht_we;
  assign phtWriteIndex    = pht_we ? s1_rec_reg.phtIndex : '0;
  assign phtWriteData     = pht_we ? new_counter : '0;
  assign btbWe            = btb_we;
  assign btbWriteIndex    = btb_we ? ToBTB_Index(s1_rec_reg.pc) : '0;
  assign btbWriteEntry    = btb_we ? BTBEntry'{tag:     ToBTB_Tag(s1_rec_reg.pc),
                                               content: ToBTB_Content(s1_rec_reg.target)}
                                   : '0;
  assign historyRestore   = restore_reg;
  assign committedHistory = history_reg;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_resolved_reg;
  logic [31:0] stat_mispredict_reg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stat_resolved_reg   <= '0;
      stat_mispredict_reg <= '0;
    end else if (accept) begin
      stat_resolved_reg <= stat_resolved_reg + 32'd1;
      if (mispredict)
        stat_mispredict_reg <= stat_mispredict_reg + 32'd1;
    end
  end

  assign statResolved   = stat_resolved_reg;
  assign statMispredict = stat_mispredict_reg;
`endif

endmodule

// File: doc/branch_predict_updater.md
# branch_predict_updater

Resolution-side counterpart of the fetch-stage branch predictor: accepts resolved branch outcomes from the execute stage and writes them back into the PHT and BTB. Its outputs are:
- PHT read-modify-write strobes, using 2-bit saturating counters.
- BTB entry writes.
- the committed global branch history, plus a restore pulse on mispredict so fetch can repair its speculative history.

It sits between the execute/branch unit and the predictor tables in FetchUnit.

## Interface
- QUEUE_DEPTH, 4, update-queue entries (power of two, ≥2)
- clk  in  1  clock
- rstN  in  1  reset, asynchronous, active-low
- resolveValid  in  1  resolved control-transfer presented
- resolveReady  out  1  queue can accept (= not full)
- resolvePC  in  32  PC of the branch
- resolveIsConditional  in  1  conditional branch (1) / unconditional jump (0)
- resolveIsTaken  in  1  actual direction (jumps: 1)
- resolveTarget  in  32  actual target PC
- resolvePredict  in  BranchPredict  prediction carried down the pipe (phtIndex, isBranchTakenPredicted, isNextPcPredicted, predictedNextPC)
- phtReadIndex  out  PHTIndex  synchronous-read address (data one cycle later)
- phtReadData  in  2  counter returned for previous cycle's phtReadIndex
- phtWe / phtWriteIndex / phtWriteData  out  1 / PHTIndex / 2  PHT write port
- btbWe / btbWriteIndex / btbWriteEntry  out  1 / BTBIndex / BTBEntry  BTB write port
- historyRestore  out  1  one-cycle pulse on mispredict
- committedHistory  out  GlobalBranchHistory  architectural history register
- statResolved / statMispredict  out  32 / 32  only with BRANCH_PRED_STATS_EN

## Operation
- Accept when resolveValid && resolveReady. All inputs are sampled only on accept.
- Mispredict is computed at accept:
  - for every branch, if (isTaken != isBranchTakenPredicted), or
  - if isTaken && (!isNextPcPredicted || predictedNextPC != resolveTarget).
  - For jumps the direction term uses isBranchTakenPredicted.
- History update at accept:
  - conditional: committedHistory <= {committedHistory[4:0], isTaken}.
  - jump: history unchanged.
- Queue: each accepted record is pushed as {pc, isConditional, isTaken, target, phtIndex}. Records are popped in order, one per cycle whenever non-empty. The pipe never stalls.
- Stage S0 (pop cycle): phtReadIndex = head.phtIndex; the record is registered into S1.
- Stage S1 computes the new counter from phtReadData (or forwarded data; see below):
  - taken: +1, saturating at 3.
  - not taken: −1, saturating at 0.
  - Encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- S1 writes:
  - phtWe = S1 valid && isConditional.
  - btbWe = S1 valid && isTaken; index = ToBTB_Index(pc), entry = {ToBTB_Tag(pc), ToBTB_Content(target)}.
  - Not-taken branches leave the BTB untouched.
- Forwarding: if the current S1 record writes phtWriteIndex equal to the record entering S1, the next-cycle S1 uses the registered forwarded counter instead of phtReadData. This covers the RAM's old-data-on-collision behaviour.
- Reset (any time, including mid-operation):
  - queue emptied, S1 invalid, queued updates discarded.
  - committedHistory = 0.
  - every output 0, except resolveReady = 1 once reset deasserts.

## Timing
- Accept in cycle T.
- committedHistory shows the new value from T+1; historyRestore is high during T+1 only.
- Empty queue: record pops at T+1 (phtReadIndex valid), phtWe/btbWe high at T+2. Table write latency is 2 cycles from accept.
- Back-to-back accepts produce back-to-back writes.
- Queue full: resolveReady = 0. There is no same-cycle push-on-pop bypass, so ready returns the cycle after a pop.
- Counter and history arithmetic is modulo their widths; queue pointers wrap at QUEUE_DEPTH.

## Configuration
- BRANCH_PRED_STATS_EN defined:
  - statResolved increments on every accept.
  - statMispredict increments on every accept flagged as mispredict.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- FetchUnitTypes gains:
  - PHTCounter (2-bit) with PHT_COUNTER_MAX/MIN.
  - BranchResolve struct (queue record).
  - UPDATE_QUEUE_DEPTH.
  - function NextPHTCounter(PHTCounter, logic taken).
- Sub-module branch_update_queue: synchronous FIFO with push/pop/full/empty/head.
- The top holds the history register, S1 register, forwarding, mispredict detection and stats.

## Test plan
- Conditional branch at pc 0x0000_1000, taken, phtIndex 0x05, phtReadData 1 → phtWe at T+2, index 0x05, data 2. BTB written with index 0x000 (pc[11:2]=0x400 → 0x000 for 10 bits), tag 0x1. historyRestore=1 if predicted NT.
- Saturation: data 3 + taken → 3; data 0 + not-taken → 0. Not-taken → btbWe=0.
- Two back-to-back taken updates to the same phtIndex, RAM returns 1 both times → writes 2 then 3 (forwarding).
- Jump: taken, predictedNextPC = target → no phtWe, btbWe=1, history unchanged, no restore. Same with wrong predictedNextPC → restore pulse.
- Six resolveValid cycles with QUEUE_DEPTH=4 and the pipe popping → ready never drops unless occupancy hits 4. Check full → ready=0 and no record lost.
- Assert rstN low between accept and write → no phtWe/btbWe, committedHistory=0, and statResolved=0 when the macro is defined.
